// File: rtl/serial_regbank_if.sv
// serial_regbank_if: byte-stream handshake between the host front-end (master) and the register bank (slave)
interface serial_regbank_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output rx_byte, rx_valid, tx_ready, input rx_ready, tx_byte, tx_valid);
    modport slave  (input rx_byte, rx_valid, tx_ready, output rx_ready, tx_byte, tx_valid);
endinterface

// File: rtl/serial_regbank.sv
// serial_regbank: command-byte parser driving a register bank with single write, single read and burst read
module serial_regbank #(
    parameter int                        NREG    = 16,
    parameter int                        NBYTES  = 4,
    parameter logic [15:0]               RO_MASK = 16'h00E0,
    parameter logic [NREG*8*NBYTES-1:0]  INIT    = '0,
    parameter logic [31:0]               BADVAL  = 32'hDEADBEEF,
    parameter int                        TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    serial_regbank_if.slave            bus,
    output logic [NREG*8*NBYTES-1:0]   regs_out,
    input  logic [NREG*8*NBYTES-1:0]   regs_in,
    output logic [NREG-1:0]            wr_stb,
    output logic [NREG-1:0]            rd_stb,
    output logic [7:0]                 err_cnt,
    output logic                       busy
);
    localparam int DW = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam logic [DW-1:0] BADW = DW'(BADVAL);

    typedef enum logic [2:0] {IDLE, CNT, WR, COMMIT, SNAP, RD} state_t;

    state_t        state;
    logic [3:0]    adr;
    logic [7:0]    n;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;
    logic [DW-1:0] wbuf;
    logic [DW-1:0] word;
    logic [DW-1:0] snap_val;
    logic [7:0]    err_nxt;
    logic [3:0]    nxt_adr;
    logic          in_range;
    logic          rx_fire;

    assign in_range     = int'(adr) < NREG;
    assign rx_fire      = bus.rx_valid & bus.rx_ready;
    assign bus.rx_ready = (state == IDLE) || (state == CNT) || (state == WR);
    assign busy         = state != IDLE;
    assign err_nxt      = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    assign nxt_adr      = (int'(adr) == NREG - 1) ? 4'd0 : adr + 4'd1;

    // Range is checked first so an out-of-range address never indexes past the buses.
    always_comb snap_val = !in_range ? BADW : RO_MASK[adr] ? regs_in[adr*DW +: DW] : regs_out[adr*DW +: DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            adr          <= '0;
            n            <= '0;
            idx          <= '0;
            timer        <= '0;
            wbuf         <= '0;
            word         <= '0;
            regs_out     <= INIT;
            wr_stb       <= '0;
            rd_stb       <= '0;
            err_cnt      <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_byte  <= '0;
        end else begin
            wr_stb <= '0;
            rd_stb <= '0;
            case (state)
                IDLE: if (rx_fire) begin
                    adr   <= bus.rx_byte[7:4];
                    idx   <= '0;
                    timer <= '0;
                    n     <= 8'd1;
                    case (bus.rx_byte[3:0])
                        4'h5:    state <= WR;
                        4'hA:    state <= SNAP;
                        4'hB:    state <= CNT;
                        default: err_cnt <= err_nxt;
                    endcase
                end
                CNT, WR: if (rx_fire) begin
                    timer <= '0;
                    if (state == CNT) begin
                        n     <= bus.rx_byte;
                        state <= (bus.rx_byte == 8'd0) ? IDLE : SNAP;
                        if (bus.rx_byte == 8'd0) err_cnt <= err_nxt;
                    end else begin
                        wbuf[{idx, 3'b000} +: 8] <= bus.rx_byte;
                        idx <= idx + IW'(1);
                        if (idx == LAST) state <= COMMIT;
                    end
                end else if (timer == TMAX) begin
                    err_cnt <= err_nxt;
                    state   <= IDLE;
                end else begin
                    timer <= timer + TW'(1);
                end
                COMMIT: begin
                    if (in_range && !RO_MASK[adr]) begin
                        regs_out[adr*DW +: DW] <= wbuf;
                        wr_stb[adr]            <= 1'b1;
                    end
                    state <= IDLE;
                end
                SNAP: begin
                    word <= snap_val;
                    if (in_range) rd_stb[adr] <= 1'b1;
                    idx   <= '0;
                    state <= RD;
                end
                RD: if (!bus.tx_valid) begin
                    bus.tx_valid <= 1'b1;
                    bus.tx_byte  <= word[{idx, 3'b000} +: 8];
                end else if (bus.tx_ready) begin
                    if (idx == LAST) begin
                        bus.tx_valid <= 1'b0;
                        idx          <= '0;
                        n            <= n - 8'd1;
                        state        <= (n > 8'd1) ? SNAP : IDLE;
                        if (n > 8'd1) adr <= nxt_adr;
                    end else begin
                        idx         <= idx + IW'(1);
                        bus.tx_byte <= word[{idx + IW'(1), 3'b000} +: 8];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_regbank.sv
// tb_serial_regbank: directed and randomized checks of the register bank against a word-level model
module tb_serial_regbank;
    localparam int          TIMEOUT = 1023;
    localparam logic [15:0] RO      = 16'h00E0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] regs_out;
    logic [511:0] regs_in;
    logic [15:0]  wr_stb;
    logic [15:0]  rd_stb;
    logic [7:0]   err_cnt;
    logic         busy;
    logic [31:0]  model [16];
    int           total = 0;
    int           bad = 0;

    serial_regbank_if bus();

    serial_regbank dut (
        .clk(clk), .reset(reset), .bus(bus), .regs_out(regs_out), .regs_in(regs_in),
        .wr_stb(wr_stb), .rd_stb(rd_stb), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int a);
        return RO[a] ? regs_in[a*32 +: 32] : model[a];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cyc = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rx_ready_wait", bus.rx_ready, 1);
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic recv_word(input logic [31:0] exp, input string tag, input bit rnd);
        logic [31:0] got = '0;
        logic [7:0]  held = '0;
        bit          stalled = 0;
        int          k = 0;
        int          cyc = 0;
        while (k < 4 && cyc < 200) begin
            @(negedge clk);
            bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.tx_valid) begin
                if (stalled) chk({tag, "_hold"}, bus.tx_byte, held);
                stalled = !bus.tx_ready;
                held    = bus.tx_byte;
                if (bus.tx_ready) begin
                    got[k*8 +: 8] = bus.tx_byte;
                    k++;
                end
            end
            cyc++;
        end
        chk({tag, "_bytes"}, k, 4);
        chk(tag, got, exp);
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d, input int gap);
        send_byte({a, 4'h5}, 0);
        for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8], gap);
        if (!RO[a]) model[a] = d;
    endtask

    task automatic read_reg(input logic [3:0] a, input string tag);
        send_byte({a, 4'hA}, 0);
        recv_word(exp_word(int'(a)), tag, 1);
    endtask

    initial begin
        logic [31:0] old;
        int          cyc;
        bus.rx_byte  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            regs_in[i*32 +: 32] = $urandom;
            model[i] = '0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_regs", 64'(regs_out == '0), 1);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_ready", bus.rx_ready, 1);

        write_reg(4'd3, 32'h12345678, 0);
        @(posedge clk); #1;
        chk("wr3_stb", wr_stb, 16'h0008);
        chk("wr3_reg", regs_out[3*32 +: 32], 32'h12345678);
        @(posedge clk); #1;
        chk("wr3_stb_off", wr_stb, 0);
        send_byte(8'h3A, 0);
        chk("rd3_lat1", bus.tx_valid, 0);
        @(posedge clk); #1;
        chk("rd3_rdstb", rd_stb, 16'h0008);
        chk("rd3_lat2", bus.tx_valid, 0);
        @(posedge clk); #1;
        chk("rd3_lat3", bus.tx_valid, 1);
        chk("rd3_byte0", bus.tx_byte, 8'h78);
        recv_word(32'h12345678, "rd3", 0);

        write_reg(4'd5, 32'hDDCCBBAA, 0);
        @(posedge clk); #1;
        chk("ro5_stb", wr_stb, 0);
        chk("ro5_reg", regs_out[5*32 +: 32], 0);
        send_byte(8'h5A, 0);
        @(posedge clk); #1;
        chk("ro5_rdstb", rd_stb, 16'h0020);
        recv_word(regs_in[5*32 +: 32], "ro5_rd", 1);

        send_byte(8'h6A, 0);
        @(posedge clk); #1;
        old = regs_in[6*32 +: 32];
        regs_in[6*32 +: 32] = ~old;
        recv_word(old, "snap6", 1);

        for (int i = 0; i < 8; i++) begin
            logic [3:0] a = 4'($urandom_range(0, 15));
            write_reg(a, $urandom, $urandom_range(0, 3));
            read_reg(a, "rnd_rw");
        end

        send_byte(8'hFB, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 3; i++) recv_word(exp_word((15 + i) % 16), "burst", 1);
        @(posedge clk); #1;
        chk("burst_idle", busy, 0);

        send_byte(8'h37, 0);
        chk("err_badcmd", err_cnt, 1);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        repeat (TIMEOUT + 3) @(posedge clk);
        #1;
        chk("err_timeout", err_cnt, 2);
        chk("timeout_idle", busy, 0);
        chk("timeout_reg0", regs_out[31:0], model[0]);
        send_byte(8'h0B, 0);
        send_byte(8'h00, 0);
        chk("err_zero_cnt", err_cnt, 3);

        write_reg(4'd9, 32'hA5C3_0F1E, TIMEOUT - 5);
        @(posedge clk); #1;
        chk("slow_wr_stb", wr_stb, 16'h0200);
        chk("slow_wr_err", err_cnt, 3);
        read_reg(4'd9, "slow_rd");

        send_byte(8'h0B, 0);
        send_byte(8'h04, 0);
        bus.tx_ready = 1'b0;
        cyc = 0;
        while (!bus.tx_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_tx_seen", bus.tx_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tx", bus.tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_cnt, 0);
        chk("mid_rst_regs", 64'(regs_out == '0), 1);
        for (int i = 0; i < 16; i++) model[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        write_reg(4'd2, 32'hCAFE_F00D, 1);
        read_reg(4'd2, "post_rst_rd");

        for (int i = 0; i < 260; i++) send_byte(8'h00, 0);
        chk("err_sat", err_cnt, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
